// File: rtl/requant_pkg.sv
// Shared defaults, FSM encoding and output saturation
// for the per-channel requantisation pipeline.
package requant_pkg;

  localparam int DEF_LANES  = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN
  } state_t;

  function automatic logic signed [63:0] sat_to(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane: scale, rounding right shift, bias add,
// saturate to the signed output width.
module requant_lane
  import requant_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [7:0]       scale,
  input  logic signed [7:0]       bias,
  input  logic        [4:0]       shift,
  output logic        [OUT_W-1:0] res
);

  localparam int PW = ACC_W + 9;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] s_x;
  logic signed [PW-1:0] p;
  logic signed [63:0]   pw;
  logic signed [63:0]   rnd;
  logic signed [63:0]   q;
  logic signed [63:0]   r;

  always_comb begin
    a_x = {{9{acc[ACC_W-1]}}, acc};
    s_x = {{(ACC_W + 1){1'b0}}, scale};
    p   = a_x * s_x;
    pw  = {{(64 - PW){p[PW-1]}}, p};
    rnd = '0;
    if (shift != 5'd0)
      rnd = 64'sd1 <<< (shift - 5'd1);
    q   = (pw + rnd) >>> shift;
    r   = q + {{56{bias[7]}}, bias};
    res = OUT_W'(sat_to(r, OUT_W));
  end

endmodule

// File: rtl/requant_channel.sv
// Requantises accumulator beats channel by channel,
// fetching per-channel scale/bias from external memory.
module requant_channel
  import requant_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        Out_Channel,
  input  logic [15:0]              Pixel_Beats,
  input  logic [4:0]               Shift,
  input  logic                     sData_valid,
  output logic                     sData_ready,
  input  logic [LANES*ACC_W-1:0]   sData_payload,
  output logic [ADDR_W-1:0]        Scale_Read_Addr,
  output logic [ADDR_W-1:0]        Bias_Read_Addr,
  input  logic [7:0]               Scale_In,
  input  logic [7:0]               Bias_In,
  output logic [LANES*OUT_W-1:0]   mData,
  output logic                     mValid,
  input  logic                     mReady,
  output logic                     mLast,
  output logic                     Busy
);

  state_t                 state_q, state_d;
  logic [15:0]            beat_q, beat_d;
  logic [15:0]            pb_q, pb_d;
  logic [ADDR_W-1:0]      chan_q, chan_d;
  logic [ADDR_W-1:0]      oc_q, oc_d;
  logic [4:0]             shift_q, shift_d;
  logic [LANES*OUT_W-1:0] mdata_q, mdata_d;
  logic                   mvalid_q, mvalid_d;
  logic                   mlast_q, mlast_d;
  logic [LANES*OUT_W-1:0] lane_out;
  logic                   xfer;
  logic                   take;
  logic                   last_beat;
  logic                   last_chan;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .acc   (sData_payload[g*ACC_W +: ACC_W]),
      .scale (Scale_In),
      .bias  (Bias_In),
      .shift (shift_q),
      .res   (lane_out[g*OUT_W +: OUT_W])
    );
  end

  assign sData_ready     = (state_q == S_RUN) && (!mvalid_q || mReady);
  assign xfer            = sData_valid && sData_ready;
  assign take            = mvalid_q && mReady;
  assign last_beat       = (beat_q == pb_q - 16'd1);
  assign last_chan       = (chan_q == oc_q - ADDR_W'(1));
  assign Scale_Read_Addr = chan_q;
  assign Bias_Read_Addr  = chan_q;
  assign mData           = mdata_q;
  assign mValid          = mvalid_q;
  assign mLast           = mlast_q;
  assign Busy            = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    pb_d     = pb_q;
    chan_d   = chan_q;
    oc_d     = oc_q;
    shift_d  = shift_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;

    if (take) begin
      mvalid_d = 1'b0;
      mlast_d  = 1'b0;
    end
    if (xfer) begin
      mdata_d  = lane_out;
      mvalid_d = 1'b1;
      mlast_d  = last_beat && last_chan;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && Out_Channel != '0 && Pixel_Beats != '0) begin
          state_d = S_PRIME;
          oc_d    = Out_Channel;
          pb_d    = Pixel_Beats;
          shift_d = Shift;
          beat_d  = '0;
          chan_d  = '0;
        end
      end
      S_PRIME: state_d = S_RUN;
      S_RUN: begin
        if (xfer) begin
          if (last_beat) begin
            beat_d = '0;
            if (last_chan) begin
              state_d = S_DRAIN;
            end else begin
              chan_d  = chan_q + ADDR_W'(1);
              state_d = S_PRIME;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (take && mlast_q) begin
          state_d = S_IDLE;
          chan_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      pb_q     <= '0;
      chan_q   <= '0;
      oc_q     <= '0;
      shift_q  <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      pb_q     <= pb_d;
      chan_q   <= chan_d;
      oc_q     <= oc_d;
      shift_q  <= shift_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
    end
  end

endmodule

// File: tb/tb_requant_channel.sv
// Directed + scoreboard bench for requant_channel.
// Expected beats are queued at input transfer.
module tb_requant_channel;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [8:0]   Out_Channel;
  logic [15:0]  Pixel_Beats;
  logic [4:0]   Shift;
  logic         sData_valid;
  logic         sData_ready;
  logic [255:0] sData_payload;
  logic [8:0]   Scale_Read_Addr;
  logic [8:0]   Bias_Read_Addr;
  logic [7:0]   Scale_In;
  logic [7:0]   Bias_In;
  logic [63:0]  mData;
  logic         mValid;
  logic         mReady;
  logic         mLast;
  logic         Busy;

  typedef struct {
    logic [63:0] d;
    logic        last;
  } exp_t;

  exp_t              sb[$];
  logic [7:0]        scale_mem [0:511];
  logic signed [7:0] bias_mem  [0:511];
  int                tests = 0;
  int                fails = 0;
  int                n_out = 0;
  int                shift_v = 0;
  bit                rnd_ready = 1'b0;

  requant_channel dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .Out_Channel     (Out_Channel),
    .Pixel_Beats     (Pixel_Beats),
    .Shift           (Shift),
    .sData_valid     (sData_valid),
    .sData_ready     (sData_ready),
    .sData_payload   (sData_payload),
    .Scale_Read_Addr (Scale_Read_Addr),
    .Bias_Read_Addr  (Bias_Read_Addr),
    .Scale_In        (Scale_In),
    .Bias_In         (Bias_In),
    .mData           (mData),
    .mValid          (mValid),
    .mReady          (mReady),
    .mLast           (mLast),
    .Busy            (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    Scale_In <= scale_mem[Scale_Read_Addr];
    Bias_In  <= bias_mem[Bias_Read_Addr];
  end

  always @(negedge clk) begin
    exp_t e;
    mReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (mValid && !mReady) begin
      tests++;
      assert (sData_ready === 1'b0) else begin
        fails++;
        $error("FAIL stall_ready got=%b want=0", sData_ready);
      end
    end
    if (mValid && mReady) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL extra_out got=%h want=none", mData);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        assert (mData === e.d) else begin
          fails++;
          $error("FAIL out_data got=%h want=%h", mData, e.d);
        end
        tests++;
        assert (mLast === e.last) else begin
          fails++;
          $error("FAIL out_last got=%b want=%b", mLast, e.last);
        end
      end
      n_out++;
    end
  end

  function automatic logic [63:0] model(input logic [255:0] pl,
                                        input int ch);
    logic [63:0]        res;
    logic signed [31:0] t;
    longint             p;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      t = pl[i*32 +: 32];
      p = longint'(t) * longint'(scale_mem[ch]);
      if (shift_v > 0) p += longint'(1) << (shift_v - 1);
      p = p >>> shift_v;
      p += longint'(bias_mem[ch]);
      if (p > 127)  p = 127;
      if (p < -128) p = -128;
      res[i*8 +: 8] = p[7:0];
    end
    return res;
  endfunction

  task automatic do_start(input int oc, input int pb);
    @(negedge clk);
    Out_Channel = 9'(oc);
    Pixel_Beats = 16'(pb);
    Shift       = 5'(shift_v);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] pl, input logic [63:0] ex,
                           input logic lst, input int ch,
                           inout int stalls);
    exp_t e;
    bit   ok;
    int   k;
    ok = 1'b0;
    k  = 0;
    sData_valid   = 1'b1;
    sData_payload = pl;
    while (!ok && k < 200) begin
      #2;
      ok = sData_ready;
      if (ok) begin
        tests++;
        assert (Scale_Read_Addr === 9'(ch) && Bias_Read_Addr === 9'(ch))
        else begin
          fails++;
          $error("FAIL addr got=%0d/%0d want=%0d",
                 Scale_Read_Addr, Bias_Read_Addr, ch);
        end
        e.d    = ex;
        e.last = lst;
        sb.push_back(e);
      end else begin
        stalls++;
      end
      @(negedge clk);
      k++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL in_timeout got=stalled want=transfer ch=%0d", ch);
    end
  endtask

  task automatic run_pass(input int oc, input int pb, input bit poke,
                          output int stalls);
    logic [255:0] pl;
    logic [31:0]  v;
    stalls = 0;
    for (int c = 0; c < oc; c++) begin
      for (int b = 0; b < pb; b++) begin
        for (int i = 0; i < 8; i++) begin
          v = $urandom;
          if ((b + i) % 3 != 0) v = 32'($urandom_range(0, 40000)) - 32'd20000;
          pl[i*32 +: 32] = v;
        end
        if (poke && c == 1 && b == 5) start = 1'b1;
        send_beat(pl, model(pl, c), (c == oc - 1) && (b == pb - 1),
                  c, stalls);
        start = 1'b0;
        if (poke && c == 1 && b == 5) begin
          tests++;
          assert (Busy === 1'b1) else begin
            fails++;
            $error("FAIL busy_start got=%b want=1", Busy);
          end
        end
      end
    end
    sData_valid = 1'b0;
  endtask

  task automatic wait_idle(input int want_out, input int base);
    int k;
    k = 0;
    while (Busy !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    #3;
    tests++;
    assert (Busy === 1'b0) else begin
      fails++;
      $error("FAIL idle_timeout got=%b want=0", Busy);
    end
    tests++;
    assert (n_out - base === want_out && sb.size() == 0) else begin
      fails++;
      $error("FAIL out_count got=%0d left=%0d want=%0d",
             n_out - base, sb.size(), want_out);
    end
  endtask

  initial begin
    int           st;
    int           base;
    logic [255:0] pl;
    logic [31:0]  v;
    reset = 1'b0; start = 1'b0; sData_valid = 1'b0;
    sData_payload = '0; Out_Channel = '0; Pixel_Beats = '0; Shift = '0;
    for (int i = 0; i < 512; i++) begin
      scale_mem[i] = 8'($urandom_range(1, 255));
      bias_mem[i]  = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    #1;
    tests++;
    assert ({mValid, mLast, sData_ready, Busy} === 4'b0) else begin
      fails++;
      $error("FAIL rst_ctrl got=%b want=0000",
             {mValid, mLast, sData_ready, Busy});
    end
    tests++;
    assert (mData === 64'h0 && Scale_Read_Addr === 9'd0
            && Bias_Read_Addr === 9'd0) else begin
      fails++;
      $error("FAIL rst_data got=%h/%0d want=0/0", mData, Scale_Read_Addr);
    end
    reset = 1'b1;

    shift_v = 3;
    do_start(4, 0);
    #1;
    tests++;
    assert (Busy === 1'b0 && sData_ready === 1'b0) else begin
      fails++;
      $error("FAIL start_pb0 got=%b want=0", Busy);
    end
    do_start(0, 5);
    #1;
    tests++;
    assert (Busy === 1'b0) else begin
      fails++;
      $error("FAIL start_oc0 got=%b want=0", Busy);
    end

    base = n_out;
    do_start(2, 3);
    run_pass(2, 3, 1'b0, st);
    tests++;
    assert (st === 2) else begin
      fails++;
      $error("FAIL prime_bubbles got=%0d want=2", st);
    end
    wait_idle(6, base);

    shift_v = 8;
    scale_mem[0] = 8'd16;
    bias_mem[0]  = 8'sd3;
    base = n_out;
    do_start(1, 2);
    st = 0;
    v = 32'd1000;
    pl = {8{v}};
    send_beat(pl, {8{8'h42}}, 1'b0, 0, st);
    v = -32'sd1000;
    pl = {8{v}};
    send_beat(pl, {8{8'hC5}}, 1'b1, 0, st);
    sData_valid = 1'b0;
    wait_idle(2, base);

    shift_v = 0;
    scale_mem[0] = 8'd255;
    bias_mem[0]  = 8'sd0;
    base = n_out;
    do_start(1, 2);
    v = 32'd100000;
    pl = {8{v}};
    send_beat(pl, {8{8'h7F}}, 1'b0, 0, st);
    v = -32'sd100000;
    pl = {8{v}};
    send_beat(pl, {8{8'h80}}, 1'b1, 0, st);
    sData_valid = 1'b0;
    wait_idle(2, base);

    shift_v = 5;
    rnd_ready = 1'b1;
    base = n_out;
    do_start(4, 25);
    run_pass(4, 25, 1'b1, st);
    wait_idle(100, base);
    rnd_ready = 1'b0;

    shift_v = 2;
    do_start(2, 3);
    st = 0;
    v = 32'd77;
    pl = {8{v}};
    send_beat(pl, model(pl, 0), 1'b0, 0, st);
    send_beat(pl, model(pl, 0), 1'b0, 0, st);
    #2;
    reset = 1'b0;
    sData_valid = 1'b0;
    #1;
    tests++;
    assert ({mValid, mLast, sData_ready, Busy} === 4'b0
            && mData === 64'h0) else begin
      fails++;
      $error("FAIL mid_reset got=%b/%h want=0",
             {mValid, mLast, sData_ready, Busy}, mData);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    base = n_out;
    do_start(1, 2);
    run_pass(1, 2, 1'b0, st);
    wait_idle(2, base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
